// File: rtl/uart_pkg.sv
// Shared encodings and defaults for the UART transmit scheduler.
package uart_pkg;

  localparam int WORD_W       = 16;
  localparam int START_TO_DEF = 16;
  localparam int FRAME_TO_DEF = 131072;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_DONE      = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_START_TO = 2'd1;
  localparam logic [1:0] ERR_FRAME_TO = 2'd2;
  localparam logic [1:0] ERR_TX_FAULT = 2'd3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first active request after ptr, with wrap.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       ptr,
  output logic             gnt_valid,
  output logic [2:0]       gnt_idx
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [3:0]         off;
  logic [3:0]         sum;

  always_comb begin
    // rot[j] corresponds to requester (ptr + 1 + j) mod N_REQ
    dbl       = {req, req};
    rot       = N_REQ'(dbl >> ({1'b0, ptr} + 4'd1));
    gnt_valid = 1'b0;
    off       = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        gnt_valid = 1'b1;
        off       = 4'(j);
      end
    end
    sum = {1'b0, ptr} + 4'd1 + off;
    if (sum >= 4'(N_REQ)) sum = sum - 4'(N_REQ);
    gnt_idx = sum[2:0];
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one 16-bit-word UART transmitter among N_REQ requesters, round-robin,
// with start/frame timeouts and a sticky fault state.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int START_TO = START_TO_DEF,
  parameter int FRAME_TO = FRAME_TO_DEF,
  parameter int TO_W     = 18
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [WORD_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]        ack,
  input  logic                    cfg_parity_en,
  input  logic                    cfg_parity_kind,
  output logic [WORD_W-1:0]       tx_data,
  output logic                    tx_start,
  output logic                    tx_parity_en,
  output logic                    tx_parity_kind,
  input  logic                    tx_busy,
  input  logic                    tx_ok,
  output logic [2:0]              grant_id,
  output logic                    busy,
  output logic [1:0]              err_code,
  input  logic                    err_clr,
  output logic [15:0]             frames_sent
);

  state_t            state_q, state_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [1:0]        err_q, err_d;
  logic [WORD_W-1:0] tx_data_q, sel_word;
  logic              par_en_q, par_kind_q;
  logic [2:0]        grant_q, ptr_q, gnt_idx;
  logic [15:0]       frames_sent_q;
  logic              gnt_valid, load, done_enter;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req       (req),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == 3'(i)) sel_word = req_data[WORD_W*i +: WORD_W];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    load       = 1'b0;
    done_enter = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (gnt_valid) begin
          state_d = S_LAUNCH;
          load    = 1'b1;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT_BUSY;
        cnt_d   = '0;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
          cnt_d   = '0;
        end else if (cnt_q == TO_W'(START_TO - 1)) begin
          state_d = S_FAULT;
          err_d   = ERR_START_TO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          state_d    = S_DONE;
          done_enter = 1'b1;
        end else if (cnt_q == TO_W'(FRAME_TO - 1)) begin
          state_d = S_FAULT;
          err_d   = ERR_FRAME_TO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: begin
        if (err_clr) begin
          state_d = S_IDLE;
          err_d   = ERR_NONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A transmitter fault outranks timeouts and busy edges seen in the same cycle
    if ((state_q inside {S_LAUNCH, S_WAIT_BUSY, S_WAIT_DONE, S_DONE}) && !tx_ok) begin
      state_d    = S_FAULT;
      err_d      = ERR_TX_FAULT;
      done_enter = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      err_q         <= ERR_NONE;
      tx_data_q     <= '0;
      par_en_q      <= 1'b0;
      par_kind_q    <= 1'b0;
      grant_q       <= 3'(N_REQ - 1);
      ptr_q         <= 3'(N_REQ - 1);
      frames_sent_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (load) begin
        grant_q    <= gnt_idx;
        tx_data_q  <= sel_word;
        par_en_q   <= cfg_parity_en;
        par_kind_q <= cfg_parity_kind;
      end
      if (done_enter) begin
        frames_sent_q <= frames_sent_q + 16'd1;
        ptr_q         <= grant_q;
      end
    end
  end

  assign tx_start       = (state_q == S_LAUNCH);
  assign busy           = (state_q != S_IDLE);
  assign ack            = (state_q == S_DONE) ? ({{(N_REQ-1){1'b0}}, 1'b1} << grant_q) : '0;
  assign tx_data        = tx_data_q;
  assign tx_parity_en   = par_en_q;
  assign tx_parity_kind = par_kind_q;
  assign grant_id       = grant_q;
  assign err_code       = err_q;
  assign frames_sent    = frames_sent_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: transmitter model, grant/ack scoreboard,
// timeout, fault, reset and counter-wrap scenarios.
module tb_uart_tx_sched;
  import uart_pkg::*;

  localparam int N_REQ    = 4;
  localparam int START_TO = 16;

  logic        clk = 1'b0;
  logic        rst_n, cfg_parity_en, cfg_parity_kind, tx_busy, tx_ok, err_clr;
  logic [3:0]  req, ack;
  logic [63:0] req_data;
  logic [15:0] tx_data, frames_sent;
  logic        tx_start, tx_parity_en, tx_parity_kind, busy;
  logic [2:0]  grant_id;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  uart_tx_sched #(.N_REQ(N_REQ), .START_TO(START_TO), .FRAME_TO(131072), .TO_W(18)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .ack(ack),
    .cfg_parity_en(cfg_parity_en), .cfg_parity_kind(cfg_parity_kind),
    .tx_data(tx_data), .tx_start(tx_start), .tx_parity_en(tx_parity_en),
    .tx_parity_kind(tx_parity_kind), .tx_busy(tx_busy), .tx_ok(tx_ok),
    .grant_id(grant_id), .busy(busy), .err_code(err_code), .err_clr(err_clr),
    .frames_sent(frames_sent)
  );

  typedef struct {
    logic [2:0]  id;
    logic [15:0] data;
    logic        pen;
    logic        pkind;
  } exp_t;

  exp_t sb[$];
  int   tests = 0, fails = 0, acks = 0, starts = 0, cyc = 0, last_ack = -100;
  int   mdl_delay = 3, mdl_hold = 200;
  bit   mdl_never = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_tx_data"}, 32'(tx_data), 0);
    check({tag, "_tx_start"}, 32'(tx_start), 0);
    check({tag, "_ack"}, 32'(ack), 0);
    check({tag, "_par_en"}, 32'(tx_parity_en), 0);
    check({tag, "_par_kind"}, 32'(tx_parity_kind), 0);
    check({tag, "_grant_id"}, 32'(grant_id), 3);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_err"}, 32'(err_code), 0);
    check({tag, "_frames"}, 32'(frames_sent), 0);
  endtask

  task automatic wait_ack(input string tag, input int bound);
    bit ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (ack != 4'b0) ok = 1'b1;
    end
    check(tag, 32'(ok), 1);
  endtask

  task automatic wait_start(input string tag, input int bound);
    bit ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (tx_start) ok = 1'b1;
    end
    check(tag, 32'(ok), 1);
  endtask

  // Transmitter model: busy rises mdl_delay edges after seeing tx_start, lasts mdl_hold cycles
  initial begin : tx_model
    int phase;
    int cnt;
    phase   = 0;
    cnt     = 0;
    tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        phase = 0;
        tx_busy <= 1'b0;
      end else begin
        case (phase)
          0: if (tx_start && !mdl_never) begin phase = 1; cnt = mdl_delay; end
          1: if (cnt <= 1) begin tx_busy <= 1'b1; phase = 2; cnt = mdl_hold; end else cnt--;
          default: if (cnt <= 1) begin tx_busy <= 1'b0; phase = 0; end else cnt--;
        endcase
      end
    end
  end

  // Scoreboard monitor: each tx_start and ack is matched against the queue head
  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (tx_start) begin
        starts++;
        check("start_gap", 32'((cyc - last_ack) >= 2), 1);
        if (sb.size() == 0) check("start_unexpected", 32'(tx_start), 0);
        else begin
          check("tx_data", 32'(tx_data), 32'(sb[0].data));
          check("grant_id", 32'(grant_id), 32'(sb[0].id));
          check("par_en", 32'(tx_parity_en), 32'(sb[0].pen));
          check("par_kind", 32'(tx_parity_kind), 32'(sb[0].pkind));
        end
      end
      if (ack != 4'b0) begin
        acks++;
        last_ack = cyc;
        if (sb.size() == 0) check("ack_unexpected", 32'(ack), 0);
        else begin
          check("ack_onehot", 32'(ack), 32'(1) << sb[0].id);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int s0, a0;
    rst_n = 1'b0; req = '0; req_data = '0; cfg_parity_en = 1'b0; cfg_parity_kind = 1'b0;
    tx_ok = 1'b1; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;

    // Single request
    req_data[15:0] = 16'hA55A;
    sb.push_back('{3'd0, 16'hA55A, 1'b0, 1'b0});
    s0 = starts;
    req = 4'b0001;
    wait_ack("single_ack", 400);
    req = '0;
    check("single_frames", 32'(frames_sent), 1);
    check("single_starts", 32'(starts - s0), 1);
    @(negedge clk);
    check("single_ack_pulse", 32'(ack), 0);
    check("single_idle", 32'(busy), 0);

    // Contention from a fresh pointer: 0,1,3 repeating
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    mdl_delay = 1; mdl_hold = 6;
    req_data = {16'h3333, 16'h0000, 16'h2222, 16'h1111};
    for (int k = 0; k < 2; k++) begin
      sb.push_back('{3'd0, 16'h1111, 1'b0, 1'b0});
      sb.push_back('{3'd1, 16'h2222, 1'b0, 1'b0});
      sb.push_back('{3'd3, 16'h3333, 1'b0, 1'b0});
    end
    a0 = acks;
    req = 4'b1011;
    for (int k = 0; k < 6; k++) wait_ack("contend_ack", 100);
    req = '0;
    check("contend_count", 32'(acks - a0), 6);
    check("contend_frames", 32'(frames_sent), 6);

    // Parity configuration latched at grant
    cfg_parity_en = 1'b1; cfg_parity_kind = 1'b1;
    req_data[47:32] = 16'h1234;
    sb.push_back('{3'd2, 16'h1234, 1'b1, 1'b1});
    req = 4'b0100;
    wait_start("par_start", 50);
    repeat (3) @(negedge clk);
    cfg_parity_en = 1'b0; cfg_parity_kind = 1'b0;
    repeat (2) @(negedge clk);
    check("par_mid_en", 32'(tx_parity_en), 1);
    check("par_mid_kind", 32'(tx_parity_kind), 1);
    wait_ack("par_ack", 100);
    req = '0;
    check("par_done_en", 32'(tx_parity_en), 1);
    check("par_done_kind", 32'(tx_parity_kind), 1);

    // Start timeout: busy never rises
    mdl_never = 1'b1;
    req_data[15:0] = 16'hC0DE;
    sb.push_back('{3'd0, 16'hC0DE, 1'b0, 1'b0});
    req = 4'b0001;
    wait_start("sto_start", 50);
    repeat (START_TO) @(negedge clk);
    check("sto_early_err", 32'(err_code), 32'(ERR_NONE));
    @(negedge clk);
    check("sto_err", 32'(err_code), 32'(ERR_START_TO));
    check("sto_busy", 32'(busy), 1);
    check("sto_no_start", 32'(tx_start), 0);
    check("sto_data_held", 32'(tx_data), 32'h0000C0DE);
    req = '0;
    repeat (3) @(negedge clk);
    check("sto_sticky", 32'(err_code), 32'(ERR_START_TO));
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    check("sto_clr_idle", 32'(busy), 0);
    check("sto_clr_err", 32'(err_code), 32'(ERR_NONE));
    void'(sb.pop_front());
    mdl_never = 1'b0;

    // Transmitter fault during the frame; err_clr ignored while not in FAULT
    mdl_hold = 50;
    req_data[31:16] = 16'hBEEF;
    sb.push_back('{3'd1, 16'hBEEF, 1'b0, 1'b0});
    a0 = acks;
    req = 4'b0010;
    wait_start("txf_start", 50);
    repeat (5) @(negedge clk);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    check("txf_clr_ignored_busy", 32'(busy), 1);
    check("txf_clr_ignored_err", 32'(err_code), 32'(ERR_NONE));
    tx_ok = 1'b0; @(negedge clk); tx_ok = 1'b1;
    check("txf_err", 32'(err_code), 32'(ERR_TX_FAULT));
    check("txf_busy", 32'(busy), 1);
    repeat (55) @(negedge clk);
    check("txf_no_ack", 32'(acks - a0), 0);
    check("txf_sticky", 32'(err_code), 32'(ERR_TX_FAULT));
    req = '0;
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    check("txf_clr_idle", 32'(busy), 0);
    check("txf_clr_err", 32'(err_code), 32'(ERR_NONE));
    void'(sb.pop_front());

    // Reset in the middle of a frame
    req_data[15:0] = 16'h5A5A;
    sb.push_back('{3'd0, 16'h5A5A, 1'b0, 1'b0});
    req = 4'b0001;
    wait_start("mrst_start", 50);
    repeat (8) @(negedge clk);
    check("mrst_in_frame", 32'(busy), 1);
    rst_n = 1'b0; req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset("mrst");
    void'(sb.pop_front());

    // Frame counter wrap from a preloaded 0xFFFF
    mdl_hold = 6;
    force dut.frames_sent_q = 16'hFFFF;
    @(negedge clk);
    release dut.frames_sent_q;
    req_data[63:48] = 16'h0F0F;
    sb.push_back('{3'd3, 16'h0F0F, 1'b0, 1'b0});
    req = 4'b1000;
    wait_ack("wrap_ack", 100);
    req = '0;
    check("wrap_frames", 32'(frames_sent), 0);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
